// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline boundary: datapath widths and
// the layout of the decoded control bundle used by decode and execute.
package id_ex_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int REG_W  = 5;

  // Control bundle field positions
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUOP_HI = 7;

  localparam int MEMREAD_BIT = CTRL_MEMREAD;

  localparam logic [15:0] HAZARD_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: upstream decoded fields with register-file read
// data, and the registered execute-side payload with its handshake.
interface id_ex_if #(
  parameter int XLEN   = id_ex_pkg::XLEN,
  parameter int CTRL_W = id_ex_pkg::CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   imm;
  logic [CTRL_W-1:0] ctrl;
  logic [XLEN-1:0]   rs1_value;
  logic [XLEN-1:0]   rs2_value;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_rs1_val;
  logic [XLEN-1:0]   ex_rs2_val;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;

  // The stage itself: consumes decode, produces execute payload
  modport slave (
    input  in_valid, rs1, rs2, rd, pc, imm, ctrl, rs1_value, rs2_value,
    output in_ready,
    output out_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
    output ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    input  out_ready
  );

  modport master (
    output in_valid, rs1, rs2, rd, pc, imm, ctrl, rs1_value, rs2_value,
    input  in_ready,
    input  out_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
    input  ex_rs1, ex_rs2, ex_rd, ex_ctrl,
    output out_ready
  );

endinterface

// File: rtl/id_ex_bypass.sv
// Operand select for one source register: x0 reads zero, a same-cycle
// write-back to the register wins over the stale register-file read.
module id_ex_bypass #(
  parameter int XLEN = id_ex_pkg::XLEN
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_value,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rf_value;
    if (rs == 5'd0) begin
      value = '0;
    end else if (wb_we && (wb_rd == rs)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall insertion,
// flush, and a saturating count of load-use stall cycles.
module id_ex_stage #(
  parameter int XLEN   = id_ex_pkg::XLEN,
  parameter int CTRL_W = id_ex_pkg::CTRL_W
) (
  input  logic            CLK,
  input  logic            RSTn,
  id_ex_if.slave          bus,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [15:0]     hazard_cnt
);
  import id_ex_pkg::*;

  logic [XLEN-1:0]   rs1_sel;
  logic [XLEN-1:0]   rs2_sel;
  logic              advance;
  logic              hazard;

  logic              out_valid_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [XLEN-1:0]   ex_rs1_val_q;
  logic [XLEN-1:0]   ex_rs2_val_q;
  logic [4:0]        ex_rs1_q;
  logic [4:0]        ex_rs2_q;
  logic [4:0]        ex_rd_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [15:0]       hazard_cnt_q;

  id_ex_bypass #(.XLEN(XLEN)) u_bypass_rs1 (
    .rs       (bus.rs1),
    .rf_value (bus.rs1_value),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .value    (rs1_sel)
  );

  id_ex_bypass #(.XLEN(XLEN)) u_bypass_rs2 (
    .rs       (bus.rs2),
    .rf_value (bus.rs2_value),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .value    (rs2_sel)
  );

  // A load sitting in EX cannot forward to the instruction right behind it;
  // the bubble inserted here drops out_valid, so the stall lasts one cycle.
  assign advance = !out_valid_q || bus.out_ready;
  assign hazard  = out_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rd_q != 5'd0) &&
                   bus.in_valid && ((ex_rd_q == bus.rs1) || (ex_rd_q == bus.rs2));

  assign bus.in_ready = flush || (advance && !hazard);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid_q  <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_rs1_val_q <= '0;
      ex_rs2_val_q <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_ctrl_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance && hazard) begin
      out_valid_q <= 1'b0;
    end else if (advance && bus.in_valid) begin
      out_valid_q  <= 1'b1;
      ex_pc_q      <= bus.pc;
      ex_imm_q     <= bus.imm;
      ex_rs1_val_q <= rs1_sel;
      ex_rs2_val_q <= rs2_sel;
      ex_rs1_q     <= bus.rs1;
      ex_rs2_q     <= bus.rs2;
      ex_rd_q      <= bus.rd;
      ex_ctrl_q    <= bus.ctrl;
    end else if (advance) begin
      out_valid_q <= 1'b0;
    end
  end

  // Counts every stalled cycle, including ones where EX is also backpressured
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hazard_cnt_q <= '0;
    end else if (hazard && !flush && (hazard_cnt_q != HAZARD_CNT_MAX)) begin
      hazard_cnt_q <= hazard_cnt_q + 16'd1;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.ex_pc      = ex_pc_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_rs1_val = ex_rs1_val_q;
  assign bus.ex_rs2_val = ex_rs2_val_q;
  assign bus.ex_rs1     = ex_rs1_q;
  assign bus.ex_rs2     = ex_rs2_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign hazard_cnt     = hazard_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, 8, decoded control bundle width; bit MEMREAD_BIT marks a load.
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1, the upstream decode handshake.
REQ-006 SHALL have ports rs1, rs2, rd in 5 each, plus pc in XLEN, imm in XLEN, ctrl in CTRL_W: the decoded fields.
REQ-007 SHALL have ports rs1_value, rs2_value in XLEN: the register-file read data for rs1/rs2.
REQ-008 SHALL have ports wb_we in 1, wb_rd in 5, wb_data in XLEN: the write-back port driving the register file this cycle.
REQ-009 SHALL have port flush in 1: squash held and incoming instruction.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1, the downstream execute handshake.
REQ-011 SHALL have outputs ex_pc, ex_imm, ex_rs1_val, ex_rs2_val (XLEN), ex_rs1, ex_rs2, ex_rd (5), ex_ctrl (CTRL_W).
REQ-012 SHALL have output hazard_cnt out 16: saturating load-use stall cycle count.

Function
REQ-013 Operand select: if rsN==0 value SHALL be 0; else if wb_we && wb_rd==rsN value SHALL be wb_data; else rsNN_value.
REQ-014 Load-use hazard SHALL be asserted when out_valid && ex_ctrl[MEMREAD_BIT] && ex_rd!=0 && in_valid && (ex_rd==rs1 || ex_rd==rs2).
REQ-015 advance SHALL equal !out_valid || out_ready.
REQ-016 in_ready SHALL equal flush || (advance && !hazard), combinationally.
REQ-017 On flush, next cycle out_valid SHALL be 0 and the input SHALL be consumed and discarded; flush overrides all other conditions.
REQ-018 Else if advance && hazard: out_valid SHALL become 0 (bubble), payload held, input not consumed.
REQ-019 Else if advance && in_valid: all ex_* SHALL capture the selected fields and out_valid SHALL become 1; latency exactly one cycle.
REQ-020 Else if advance: out_valid SHALL become 0; payload registers need not change.
REQ-021 Else (out_valid && !out_ready): all outputs SHALL hold stable.
REQ-022 hazard_cnt SHALL increment each cycle hazard && !flush is 1, saturating at 0xFFFF (no wrap).
REQ-023 A hazard SHALL stall at most one cycle per load, since the bubble clears the match next cycle.
REQ-024 Bypass SHALL apply to the value captured in the same edge as the write-back, including wb_rd==rs1==rs2.

Reset
REQ-025 RSTn low SHALL immediately force out_valid=0, all ex_* =0, hazard_cnt=0, independent of CLK.
REQ-026 Reset mid-handshake SHALL drop the held instruction; first capture after deassertion is the first edge with in_valid && in_ready.
REQ-027 in_ready SHALL be computed from reset-state registers during reset (1 when not hazard).

Structure
REQ-028 Package id_ex_pkg SHALL hold XLEN, CTRL_W, MEMREAD_BIT and the ctrl-bundle field indices, shared with decode and execute.
REQ-029 Sub-module id_ex_bypass SHALL implement REQ-013 combinationally, instantiated twice (rs1, rs2).
REQ-030 Hazard logic, handshake and counter SHALL reside in id_ex_stage.

Verification
REQ-031 Plain pass: rs1=3, rs1_value=0x11, in_valid=1, out_ready=1 -> next cycle out_valid=1, ex_rs1_val=0x11.
REQ-032 Bypass: rs2=5, rs2_value=0x0, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> ex_rs2_val=0xDEADBEEF; rs2=0 with same wb -> 0.
REQ-033 Load-use: held ctrl MEMREAD=1, ex_rd=7; incoming rs1=7 -> in_ready=0 one cycle, bubble out_valid=0, next cycle capture, hazard_cnt=1.
REQ-034 Backpressure: out_ready=0 for 3 cycles -> in_ready=0, ex_* stable all 3 cycles, no input lost.
REQ-035 Flush during hazard and during stall -> in_ready=1, next out_valid=0, hazard_cnt unchanged.
REQ-036 Async reset asserted mid-cycle with out_valid=1 -> out_valid=0 before next CLK edge; hazard_cnt forced to 0xFFFF then one more hazard -> stays 0xFFFF.
